// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter arbiter: default sizing and FSM encoding.
package serial_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16384;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for serial_tx_arbiter.
interface serial_tx_arbiter_if
    import serial_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        err;
    logic                    tx_enable;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;
    logic                    tx_done;
    logic                    busy;

    // master is the arbiter side; slave is the requesters plus transmitter
    modport master (
        input  req, req_data, tx_busy, tx_done,
        output grant, ack, err, tx_enable, tx_data, busy
    );

    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  grant, ack, err, tx_enable, tx_data, busy
    );

endinterface

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after last, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDXW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  last,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    always_comb begin
        int idx;
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a serial transmitter,
// with a grant-to-done watchdog.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no owner; arbitrate on any req
//   ST_START | owner granted, tx_enable high until the transmitter reports busy
//   ST_WAIT  | frame in flight, waiting for tx_done or the watchdog
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                fpga_clock,
    input  logic                reset_n,
    serial_tx_arbiter_if.master bus
);

    localparam int IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(N_REQ - 1);

    state_t            state, state_nx;
    logic [IDXW-1:0]   owner, owner_nx;
    logic [IDXW-1:0]   last, last_nx;
    logic [N_REQ-1:0]  grant_q, grant_nx;
    logic [N_REQ-1:0]  ack_q, ack_nx;
    logic [N_REQ-1:0]  err_q, err_nx;
    logic              tx_en_q, tx_en_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    logic [N_REQ-1:0]  pick;
    logic              pick_valid;
    logic [IDXW-1:0]   pick_idx;
    logic              timeout_hit;
    logic              finish;

    rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_rr_pick (
        .req   (bus.req),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = IDXW'(i);
        end
    end

    // counter holds cycles elapsed since grant minus one, so the compare fires on cycle TIMEOUT
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        grant_nx = grant_q;
        ack_nx   = '0;
        err_nx   = '0;
        tx_en_nx = tx_en_q;
        data_nx  = data_q;
        cnt_nx   = cnt;
        finish   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx = ST_START;
                    owner_nx = pick_idx;
                    grant_nx = pick;
                    data_nx  = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    tx_en_nx = 1'b1;
                    cnt_nx   = '0;
                end
            end
            ST_START, ST_WAIT: begin
                cnt_nx = cnt + 1'b1;
                if (bus.tx_done) begin
                    ack_nx = grant_q;
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    err_nx = grant_q;
                    finish = 1'b1;
                end else if (state == ST_START && bus.tx_busy) begin
                    state_nx = ST_WAIT;
                    tx_en_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (finish) begin
            state_nx = ST_IDLE;
            grant_nx = '0;
            tx_en_nx = 1'b0;
            data_nx  = '0;
            cnt_nx   = '0;
            last_nx  = owner;
        end
    end

    always_ff @(posedge fpga_clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            owner   <= '0;
            last    <= LAST_RST;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            tx_en_q <= 1'b0;
            data_q  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            last    <= last_nx;
            grant_q <= grant_nx;
            ack_q   <= ack_nx;
            err_q   <= err_nx;
            tx_en_q <= tx_en_nx;
            data_q  <= data_nx;
            cnt     <= cnt_nx;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.tx_enable = tx_en_q;
    assign bus.tx_data   = data_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: default-timeout instance for arbitration and
// data paths, TIMEOUT=100 instance for watchdog and collision cases.
module tb_serial_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bif_a ();
    serial_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bif_b ();

    serial_tx_arbiter u_dut_a (
        .fpga_clock (clk),
        .reset_n    (rst_n),
        .bus        (bif_a.master)
    );

    serial_tx_arbiter #(.TIMEOUT(100)) u_dut_b (
        .fpga_clock (clk),
        .reset_n    (rst_n),
        .bus        (bif_b.master)
    );

    // sel routes the bench stimulus to one instance; the other sees idle inputs
    logic        sel;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_busy, tx_done;

    assign bif_a.req      = sel ? 4'b0  : req;
    assign bif_a.req_data = sel ? 32'b0 : req_data;
    assign bif_a.tx_busy  = sel ? 1'b0  : tx_busy;
    assign bif_a.tx_done  = sel ? 1'b0  : tx_done;
    assign bif_b.req      = sel ? req      : 4'b0;
    assign bif_b.req_data = sel ? req_data : 32'b0;
    assign bif_b.tx_busy  = sel ? tx_busy  : 1'b0;
    assign bif_b.tx_done  = sel ? tx_done  : 1'b0;

    wire [3:0] grant     = sel ? bif_b.grant     : bif_a.grant;
    wire [3:0] ack       = sel ? bif_b.ack       : bif_a.ack;
    wire [3:0] err       = sel ? bif_b.err       : bif_a.err;
    wire       tx_enable = sel ? bif_b.tx_enable : bif_a.tx_enable;
    wire [7:0] tx_data   = sel ? bif_b.tx_data   : bif_a.tx_data;
    wire       busy      = sel ? bif_b.busy      : bif_a.busy;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   32'(grant),     32'h0);
        chk({tag, "_ack"},     32'(ack),       32'h0);
        chk({tag, "_err"},     32'(err),       32'h0);
        chk({tag, "_tx_en"},   32'(tx_enable), 32'h0);
        chk({tag, "_tx_data"}, 32'(tx_data),   32'h0);
        chk({tag, "_busy"},    32'(busy),      32'h0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        logic stray;

        // Sequence begins with last_winner = 3 (after the fairness run)
        vecs[0] = '{4'b0001, 32'h44332211, 4'b0001, 8'h11};
        vecs[1] = '{4'b0101, 32'h0F1E2D3C, 4'b0100, 8'h1E};
        vecs[2] = '{4'b0101, 32'h99887766, 4'b0001, 8'h66};
        vecs[3] = '{4'b1000, 32'hDEADBEEF, 4'b1000, 8'hDE};
        vecs[4] = '{4'b1010, 32'h12345678, 4'b0010, 8'h56};
        vecs[5] = '{4'b1010, 32'hCAFEF00D, 4'b1000, 8'hCA};
        vecs[6] = '{4'b0110, 32'h5A6B7C8D, 4'b0010, 8'h7C};

        sel = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        rst_n = 1'b0;

        // reset: requests present but nothing granted while reset is low
        req = 4'b1111;
        req_data = 32'h03020100;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // fairness: all four requesting, strict rotation with an idle gap
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            chk("rr_data", 32'(tx_data), 32'(k % 4));
            tx_busy = 1'b1;
            tick();
            tx_busy = 1'b0;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("rr_ack", 32'(ack), 32'(4'b0001 << (k % 4)));
            chk("rr_gap_busy", 32'(busy), 32'h0);
        end
        req = '0;
        tick();

        // table-driven transfers
        for (int v = 0; v < 7; v++) begin
            req = vecs[v].req;
            req_data = vecs[v].data;
            tick();
            chk("vec_grant", 32'(grant), 32'(vecs[v].exp_grant));
            chk("vec_data", 32'(tx_data), 32'(vecs[v].exp_byte));
            chk("vec_tx_en", 32'(tx_enable), 32'h1);
            req = '0;
            tx_busy = 1'b1;
            tick();
            chk("vec_tx_en_drop", 32'(tx_enable), 32'h0);
            tx_busy = 1'b0;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("vec_ack", 32'(ack), 32'(vecs[v].exp_grant));
            chk("vec_err", 32'(err), 32'h0);
            chk("vec_grant_clr", 32'(grant), 32'h0);
            tick();
            chk("vec_ack_clr", 32'(ack), 32'h0);
        end

        // single long transfer with req and req_data disturbed mid-flight
        req = 4'b0001;
        req_data = 32'h00000055;
        tick();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_data", 32'(tx_data), 32'h55);
        chk("single_tx_en", 32'(tx_enable), 32'h1);
        tick();
        tick();
        chk("single_tx_en_hold", 32'(tx_enable), 32'h1);
        tx_busy = 1'b1;
        req = 4'b0000;
        req_data = 32'hFFFFFFAA;
        tick();
        chk("single_tx_en_drop", 32'(tx_enable), 32'h0);
        stray = 1'b0;
        for (int i = 0; i < 4340; i++) begin
            tick();
            if (ack != 0 || err != 0 || tx_data != 8'h55 || grant != 4'b0001) stray = 1'b1;
        end
        chk("single_hold", 32'(stray), 32'h0);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_err", 32'(err), 32'h0);
        tick();
        chk("single_ack_pulse", 32'(ack), 32'h0);

        // watchdog instance: timeout then collision
        req_data = 32'h0;
        sel = 1'b1;
        req = 4'b0011;
        tick();
        chk("to_grant", 32'(grant), 32'h1);
        tx_busy = 1'b1;
        n = 0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (err != 0 || ack != 0) begin
                n = i;
                break;
            end
        end
        chk("to_cycles", 32'(n), 32'd100);
        chk("to_err", 32'(err), 32'h1);
        chk("to_no_ack", 32'(ack), 32'h0);
        chk("to_grant_clr", 32'(grant), 32'h0);
        tick();
        chk("to_next_grant", 32'(grant), 32'h2);
        stray = 1'b0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (err != 0 || ack != 0) stray = 1'b1;
        end
        chk("coll_early", 32'(stray), 32'h0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_busy = 1'b0;
        req = '0;
        chk("coll_ack", 32'(ack), 32'h2);
        chk("coll_err", 32'(err), 32'h0);
        tick();
        sel = 1'b0;

        // reset mid-WAIT, then restored priority of req[0]
        req = 4'b0001;
        req_data = 32'h00000077;
        tick();
        chk("rst_pre_grant", 32'(grant), 32'h1);
        tx_busy = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tx_busy = 1'b0;
        req = 4'b1001;
        tick();
        rst_n = 1'b1;
        chk("rst_hold_grant", 32'(grant), 32'h0);
        tick();
        chk("rst_prio_grant", 32'(grant), 32'h1);
        rst_n = 1'b0;
        req = 4'b1000;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_only3_grant", 32'(grant), 32'h8);
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
